centroid_divider: RTL and testbench
===================================

CENTROID_DIVIDER -- requirements
Module: centroid_divider

Interface
REQ-001 SHALL have parameter INIT_CENTROID, default 24'h808080, giving the centroid value after reset, packed {R,G,B}.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one centroid update using the current acc_in/count_in.
REQ-005 SHALL have port acc_in  input  72  per-cluster channel sums {red[71:48], green[47:24], blue[23:0]}, unsigned.
REQ-006 SHALL have port count_in  input  12  number of pixels accumulated for the cluster, unsigned.
REQ-007 SHALL have port centroid  output  24  current cluster mean {R[23:16], G[15:8], B[7:0]}, registered.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking a completed update attempt.
REQ-010 SHALL have port empty  output  1  registered flag: last completed update had count_in == 0.

Function
REQ-011 SHALL implement states IDLE, DIVIDE and FINISH.
REQ-012 SHALL, in IDLE with start=1 and count_in!=0, latch acc_in and count_in, clear the bit counter to 23 and enter DIVIDE at that edge (edge T0).
REQ-013 SHALL, in DIVIDE, run three parallel restoring divisions (24-bit dividend / 12-bit divisor), one quotient bit per cycle, MSB first, for exactly 24 cycles.
REQ-014 SHALL enter FINISH at edge T24 and, at edge T25, load centroid, clear empty, assert done and return to IDLE; done is high for exactly one cycle (T25 to T26).
REQ-015 SHALL truncate each quotient; there is no rounding.
REQ-016 SHALL saturate each channel to 8'hFF when its 24-bit quotient exceeds 255.
REQ-017 SHALL, in IDLE with start=1 and count_in==0, skip division, hold centroid unchanged, set empty=1 and assert done at edge T1, then remain in IDLE.
REQ-018 SHALL hold busy=1 from edge T0 until edge T25 (DIVIDE and FINISH), and busy=0 otherwise; for the zero-count path, busy stays 0.
REQ-019 SHALL ignore start while busy=1; the latched operands are not disturbed.
REQ-020 SHALL accept a new start in the same cycle that done is high (back-to-back operation).
REQ-021 SHALL keep centroid stable between updates; centroid changes only at the edge that asserts done.

Reset
REQ-022 SHALL, on reset assertion, immediately force state=IDLE, centroid=INIT_CENTROID, busy=0, done=0, empty=0, and clear all divider registers.
REQ-023 SHALL abort a division in progress on reset mid-operation without producing a done pulse or any partial centroid update.
REQ-024 SHALL treat start as ignored during the cycle in which reset deasserts if the reset is still sampled high at that edge.

Structure
REQ-025 SHALL take CH_W=8, ACC_W=24, CNT_W=12 and the state enumeration from the shared package kmeans_pkg.
REQ-026 SHALL instantiate sub-module serial_divider three times, once per channel; it has ports clk, reset, load, dividend[23:0], divisor[11:0], and quotient[23:0] valid after 24 steps.
REQ-027 SHALL keep sequencing (state machine, bit counter, saturation, output registers) in centroid_divider itself.

Verification
REQ-028 SHALL cover: acc_in={24'd2550, 24'd1000, 24'd0}, count_in=10, start -> done at T25, centroid=24'hFF6400, empty=0.
REQ-029 SHALL cover: count_in=0, start -> done at T1, empty=1, centroid unchanged (24'h808080 after reset), busy never high.
REQ-030 SHALL cover truncation and saturation: red sum 7 with count 2 -> R=8'h03; red sum 24'hFFFFFF with count 1 -> R=8'hFF.
REQ-031 SHALL cover start pulsed again at T5 with different operands -> ignored; result matches the first operands; a start in the done cycle begins a second update completing 25 cycles later.
REQ-032 SHALL cover reset asserted at T10 -> centroid=24'h808080, busy=0, and no done pulse until a new start.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared widths, state encoding and helpers for the k-means centroid datapath.
package kmeans_pkg;

  localparam int CH_W  = 8;
  localparam int ACC_W = 24;
  localparam int CNT_W = 12;
  localparam int BIT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_e;

  // A mean channel value wider than 8 bits clamps to full scale.
  function automatic logic [CH_W-1:0] saturate(input logic [ACC_W-1:0] q);
    logic [CH_W-1:0] res;
    if (q[ACC_W-1:CH_W] != '0) res = {CH_W{1'b1}};
    else                       res = q[CH_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider: one quotient bit per clock, MSB first, 24 steps after load.
module serial_divider
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [ACC_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [ACC_W-1:0] quotient
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [ACC_W-1:0] dvd_q, dvd_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;

  // Steps run every cycle; the sequencer samples the quotient right after the 24th step.
  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    dvd_d = dvd_q;
    quo_d = quo_q;
    trial = {rem_q, dvd_q[ACC_W-1]};
    diff  = trial - {1'b0, div_q};
    if (load) begin
      rem_d = '0;
      div_d = divisor;
      dvd_d = dividend;
      quo_d = '0;
    end else begin
      dvd_d = {dvd_q[ACC_W-2:0], 1'b0};
      if (trial >= {1'b0, div_q}) begin
        rem_d = diff[CNT_W-1:0];
        quo_d = {quo_q[ACC_W-2:0], 1'b1};
      end else begin
        rem_d = trial[CNT_W-1:0];
        quo_d = {quo_q[ACC_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      div_q <= '0;
      dvd_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      dvd_q <= dvd_d;
      quo_q <= quo_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/centroid_divider.sv
// Cluster centroid update: divides the three channel sums by the pixel count
// with serial dividers and registers the saturated mean.
module centroid_divider
  import kmeans_pkg::*;
#(
  parameter logic [3*CH_W-1:0] INIT_CENTROID = 24'h808080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3*ACC_W-1:0] acc_in,
  input  logic [CNT_W-1:0]   count_in,
  output logic [3*CH_W-1:0]  centroid,
  output logic               busy,
  output logic               done,
  output logic               empty
);

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              zero_pend_q, zero_pend_d;
  logic [3*CH_W-1:0] centroid_q, centroid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              empty_q, empty_d;
  logic              load;
  logic [ACC_W-1:0]  quo_r, quo_g, quo_b;

  serial_divider u_div_r (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dividend (acc_in[3*ACC_W-1:2*ACC_W]),
    .divisor  (count_in),
    .quotient (quo_r)
  );

  serial_divider u_div_g (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dividend (acc_in[2*ACC_W-1:ACC_W]),
    .divisor  (count_in),
    .quotient (quo_g)
  );

  serial_divider u_div_b (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dividend (acc_in[ACC_W-1:0]),
    .divisor  (count_in),
    .quotient (quo_b)
  );

  // An empty cluster takes one extra IDLE cycle to report, so done always
  // comes from a register and is never combinational on start.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    zero_pend_d = 1'b0;
    centroid_d  = centroid_q;
    done_d      = 1'b0;
    empty_d     = empty_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (zero_pend_q) begin
          done_d  = 1'b1;
          empty_d = 1'b1;
        end else if (start) begin
          if (count_in != '0) begin
            load      = 1'b1;
            bit_cnt_d = BIT_W'(ACC_W - 1);
            state_d   = DIVIDE;
          end else begin
            zero_pend_d = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (bit_cnt_q == '0) state_d = FINISH;
        else                 bit_cnt_d = bit_cnt_q - 1'b1;
      end
      FINISH: begin
        centroid_d = {saturate(quo_r), saturate(quo_g), saturate(quo_b)};
        empty_d    = 1'b0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      zero_pend_q <= 1'b0;
      centroid_q  <= INIT_CENTROID;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      zero_pend_q <= zero_pend_d;
      centroid_q  <= centroid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      empty_q     <= empty_d;
    end
  end

  assign centroid = centroid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign empty    = empty_q;

endmodule

// File: tb/tb_centroid_divider.sv
// Directed bench for centroid_divider: vector table plus hand-written
// sequences for start-while-busy, back-to-back and mid-operation reset.
module tb_centroid_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [71:0] acc_in;
  logic [11:0] count_in;
  logic [23:0] centroid;
  logic        busy;
  logic        done;
  logic        empty;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [71:0] acc;
    logic [11:0] cnt;
    logic [23:0] expCentroid;
    logic        expEmpty;
    int          expLat;
  } vec_t;

  vec_t vecs[7];

  centroid_divider #(.INIT_CENTROID(24'h808080)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .acc_in   (acc_in),
    .count_in (count_in),
    .centroid (centroid),
    .busy     (busy),
    .done     (done),
    .empty    (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (T0).
  task automatic applyStimulus(input logic [71:0] acc, input logic [11:0] cnt);
    acc_in   = acc;
    count_in = cnt;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts negedges until done is seen; lat = -1 when the bound expires.
  task automatic waitDone(output int lat, output bit busySeen);
    lat = 0;
    busySeen = 1'b0;
    while (!done && lat < 40) begin
      if (busy) busySeen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int  lat;
    bit  busySeen;
    bit  doneSeen;
    bit  busyAfter;

    vecs[0] = '{{24'd5, 24'd5, 24'd5},              12'd0,    24'h808080, 1'b1, 1};
    vecs[1] = '{{24'd2550, 24'd1000, 24'd0},        12'd10,   24'hFF6400, 1'b0, 25};
    vecs[2] = '{{24'd7, 24'd9, 24'd1},              12'd2,    24'h030400, 1'b0, 25};
    vecs[3] = '{{24'hFFFFFF, 24'd200, 24'd255},     12'd1,    24'hFFC8FF, 1'b0, 25};
    vecs[4] = '{{24'd1, 24'd2, 24'd3},              12'd0,    24'hFFC8FF, 1'b1, 1};
    vecs[5] = '{{24'd1044225, 24'd1048319, 24'd12}, 12'd4095, 24'hFFFF00, 1'b0, 25};
    vecs[6] = '{{24'd100, 24'd50, 24'd25},          12'd7,    24'h0E0703, 1'b0, 25};

    reset    = 1'b1;
    start    = 1'b0;
    acc_in   = '0;
    count_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_centroid", 32'(centroid), 32'h808080);
    checkOutput("reset_busy",     32'(busy),     32'd0);
    checkOutput("reset_done",     32'(done),     32'd0);
    checkOutput("reset_empty",    32'(empty),    32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].acc, vecs[i].cnt);
      waitDone(lat, busySeen);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d_centroid", i), 32'(centroid), 32'(vecs[i].expCentroid));
      checkOutput($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].expEmpty));
      checkOutput($sformatf("v%0d_busy_during", i), 32'(busySeen), 32'(vecs[i].expLat == 25));
      checkOutput($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Start again at T5 with other operands must be ignored.
    applyStimulus({24'd30, 24'd60, 24'd90}, 12'd3);
    repeat (4) @(negedge clk);
    acc_in   = {24'd900, 24'd900, 24'd900};
    count_in = 12'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    waitDone(lat, busySeen);
    checkOutput("ignore_latency",  32'(lat),      32'd20);
    checkOutput("ignore_busy",     32'(busySeen), 32'd1);
    checkOutput("ignore_centroid", 32'(centroid), 32'h0A141E);
    // Back-to-back: start issued in the done cycle.
    applyStimulus({24'd50, 24'd40, 24'd30}, 12'd10);
    checkOutput("b2b_busy_t0",    32'(busy),     32'd1);
    checkOutput("b2b_hold",       32'(centroid), 32'h0A141E);
    waitDone(lat, busySeen);
    checkOutput("b2b_latency",    32'(lat),      32'd25);
    checkOutput("b2b_centroid",   32'(centroid), 32'h050403);
    @(negedge clk);

    // Reset asserted just after T10 aborts the division.
    applyStimulus({24'd2550, 24'd1000, 24'd0}, 12'd10);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_centroid", 32'(centroid), 32'h808080);
    checkOutput("abort_busy",     32'(busy),     32'd0);
    checkOutput("abort_done",     32'(done),     32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    doneSeen  = 1'b0;
    busyAfter = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
      if (busy) busyAfter = 1'b1;
    end
    checkOutput("abort_no_done",  32'(doneSeen),  32'd0);
    checkOutput("abort_no_busy",  32'(busyAfter), 32'd0);
    checkOutput("abort_hold",     32'(centroid),  32'h808080);
    applyStimulus({24'd7, 24'd9, 24'd1}, 12'd2);
    waitDone(lat, busySeen);
    checkOutput("restart_latency",  32'(lat),      32'd25);
    checkOutput("restart_centroid", 32'(centroid), 32'h030400);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
